// File: rtl/mem_types_pkg.sv
// Shared memory-subsystem types: word width, RAM status encoding and the
// arbiter's grant states.
package mem_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // True when the RAM has finished the access currently presented to it.
    function automatic logic ram_done(ramstate_t s);
        return (s == ACCESS);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester- and RAM-side bus of the RAM arbiter. The slave modport is the
// arbiter's view; the master modport is the view of whatever surrounds it
// (requesters plus RAM).
interface ram_arbiter_if;
    import mem_types_pkg::*;

    // instruction fetch port
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // data port
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter_watchdog.sv
// Grant watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT-th enabled cycle occurs.
module ram_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    // Expiry is combinational so the owner can be dropped in the same cycle.
    assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

    // Cycle counter; clear wins over enable.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// RAM arbiter: sole master of the variable-latency RAM, sharing it between
// the instruction-fetch port and the data port. Data normally wins, but a
// waiting instruction fetch is forced through after MAX_D_STREAK data
// grants in a row. Address/controls of the owner are passed straight to
// the RAM until it reports ACCESS.
// Optional build macro: RAM_ARB_STATS_EN adds i_count, d_count and
// stall_cycles counters.
module ram_arbiter
    import mem_types_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus,
    output logic          ram_err,
    output logic          timeout
`ifdef RAM_ARB_STATS_EN
    ,
    output word_t         i_count,
    output word_t         d_count,
    output word_t         stall_cycles
`endif
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state_reg, state_next;
    logic [SW-1:0] streak_reg, streak_next;
    word_t         iload_reg, dload_reg;
    logic          timeout_reg;
    logic          err_seen_reg;

    logic granted;
    logic d_req;
    logic i_done, d_done;
    logic wd_clear, wd_en, wd_expired;

    assign granted  = (state_reg != IDLE);
    assign d_req    = bus.dREN | bus.dWEN;
    assign wd_clear = (state_reg == IDLE);
    assign wd_en    = granted && !ram_done(bus.ramstate);

    ram_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // Arbitration, RAM drive and completion detection.
    always_comb begin
        state_next   = state_reg;
        streak_next  = streak_reg;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_req && !(bus.iREN && streak_reg == STREAK_MAX)) begin
                    state_next = DGRANT;
                end else if (bus.iREN) begin
                    state_next = IGRANT;
                end
            end
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    state_next = IDLE;                  // abort
                end else if (ram_done(bus.ramstate)) begin
                    i_done      = 1'b1;
                    state_next  = IDLE;
                    streak_next = '0;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            DGRANT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req) begin
                    state_next = IDLE;                  // abort
                end else if (ram_done(bus.ramstate)) begin
                    d_done     = 1'b1;
                    state_next = IDLE;
                    if (!bus.iREN) begin
                        streak_next = '0;
                    end else if (streak_reg != STREAK_MAX) begin
                        streak_next = streak_reg + 1'b1;
                    end
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Requester-facing results: waits drop and loads bypass only on completion.
    always_comb begin
        bus.iwait = !i_done;
        bus.dwait = !d_done;
        bus.iload = i_done ? bus.ramload : iload_reg;
        bus.dload = d_done ? bus.ramload : dload_reg;
        ram_err   = granted && (bus.ramstate == ERROR) && !err_seen_reg;
        timeout   = timeout_reg;
    end

    // State, streak, held loads, sticky timeout and ERROR edge history.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            streak_reg   <= '0;
            iload_reg    <= '0;
            dload_reg    <= '0;
            timeout_reg  <= 1'b0;
            err_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            streak_reg   <= streak_next;
            if (i_done) iload_reg <= bus.ramload;
            if (d_done) dload_reg <= bus.ramload;
            timeout_reg  <= timeout_reg | wd_expired;
            err_seen_reg <= granted && (bus.ramstate == ERROR);
        end
    end

`ifdef RAM_ARB_STATS_EN
    word_t i_count_reg, d_count_reg, stall_reg;
    logic  stalled;

    assign stalled      = (bus.iREN && !i_done) || (d_req && !d_done);
    assign i_count      = i_count_reg;
    assign d_count      = d_count_reg;
    assign stall_cycles = stall_reg;

    // Free-running, wrapping statistics counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            i_count_reg <= '0;
            d_count_reg <= '0;
            stall_reg   <= '0;
        end else begin
            i_count_reg <= i_count_reg + WORD_W'(i_done);
            d_count_reg <= d_count_reg + WORD_W'(d_done);
            stall_reg   <= stall_reg + WORD_W'(stalled);
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: reset checks, a cycle table, directed multi-cycle
// sequences against a small latency RAM, and randomized traffic compared
// with a transaction-level model (owner, streak, grant age, held loads).
module tb_ram_arbiter;
    import mem_types_pkg::*;

    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ram_arbiter_if bus();
    logic ram_err, timeout;
`ifdef RAM_ARB_STATS_EN
    word_t i_count, d_count, stall_cycles;
`endif

    ram_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus.slave),
        .ram_err (ram_err),
        .timeout (timeout)
`ifdef RAM_ARB_STATS_EN
        ,
        .i_count      (i_count),
        .d_count      (d_count),
        .stall_cycles (stall_cycles)
`endif
    );

    // ---------------- RAM stand-in: scripted or small latency model ----------
    logic      ram_mode;
    ramstate_t stim_state;
    word_t     stim_load;
    word_t     mem [0:255];
    logic      rm_prev_en;
    word_t     rm_prev_addr;
    int        rm_cnt;
    int        rm_live;
    ramstate_t rm_state;
    logic      rm_en;
    localparam int RM_LAT = 2;

    assign rm_en = bus.ramREN | bus.ramWEN;

    always_comb begin
        rm_live  = 0;
        rm_state = FREE;
        if (rm_en && rm_prev_en && bus.ramaddr == rm_prev_addr) rm_live = rm_cnt + 1;
        if (rm_en) begin
            if (bus.ramREN && bus.ramWEN) rm_state = ERROR;
            else if (rm_live >= RM_LAT)   rm_state = ACCESS;
            else                          rm_state = BUSY;
        end
    end

    assign bus.ramstate = ram_mode ? rm_state : stim_state;
    assign bus.ramload  = ram_mode ? mem[bus.ramaddr[9:2]] : stim_load;

    always @(posedge CLK) begin
        rm_prev_en   <= rm_en;
        rm_prev_addr <= bus.ramaddr;
        rm_cnt       <= rm_live;
        if (ram_mode && rm_state == ACCESS && bus.ramWEN && !bus.ramREN)
            mem[bus.ramaddr[9:2]] <= bus.ramstore;
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit verbose = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int    m_owner;     // 0 none, 1 instruction, 2 data
    int    m_streak;
    int    m_age;       // grant cycles without ACCESS
    logic  m_tmo;
    logic  m_err_prev;
    word_t m_iload, m_dload;
    int    m_icnt, m_dcnt, m_stall;

    logic  obs_idone, obs_ddone, obs_err, obs_tmo, obs_iwait, obs_ren;
    word_t obs_dload;

    task automatic model_reset();
        m_owner = 0; m_streak = 0; m_age = 0; m_tmo = 1'b0; m_err_prev = 1'b0;
        m_iload = '0; m_dload = '0; m_icnt = 0; m_dcnt = 0; m_stall = 0;
    endtask

    // Check one cycle against the model, then advance both across a clock edge.
    task automatic cycle();
        logic dreq, granted, idone, ddone, e_ren, e_wen, e_err, req, expire;
        word_t e_addr, e_store, e_iload, e_dload;
        ramstate_t rs;
        int n_owner;
        rs = bus.ramstate;
        dreq = bus.dREN | bus.dWEN;
        granted = (m_owner != 0);
        idone = 1'b0; ddone = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = '0; e_store = '0;
        if (m_owner == 1) begin
            e_ren = 1'b1; e_addr = bus.iaddr;
            idone = bus.iREN && rs == ACCESS;
        end else if (m_owner == 2) begin
            e_ren = bus.dREN; e_wen = bus.dWEN; e_addr = bus.daddr; e_store = bus.dstore;
            ddone = dreq && rs == ACCESS;
        end
        e_iload = idone ? bus.ramload : m_iload;
        e_dload = ddone ? bus.ramload : m_dload;
        e_err   = granted && rs == ERROR && !m_err_prev;

        chk("ramREN",   bus.ramREN,   e_ren);
        chk("ramWEN",   bus.ramWEN,   e_wen);
        chk("ramaddr",  bus.ramaddr,  e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("iwait",    bus.iwait,    !idone);
        chk("dwait",    bus.dwait,    !ddone);
        chk("iload",    bus.iload,    e_iload);
        chk("dload",    bus.dload,    e_dload);
        chk("ram_err",  ram_err,      e_err);
        chk("timeout",  timeout,      m_tmo);
`ifdef RAM_ARB_STATS_EN
        chk("i_count",      i_count,      m_icnt);
        chk("d_count",      d_count,      m_dcnt);
        chk("stall_cycles", stall_cycles, m_stall);
`endif
        obs_idone = !bus.iwait; obs_ddone = !bus.dwait; obs_err = ram_err;
        obs_tmo = timeout; obs_iwait = bus.iwait; obs_dload = bus.dload; obs_ren = bus.ramREN;
        if (verbose && (idone || ddone))
            $display("txn %s addr=%h load=%h cyc=%0d", idone ? "I" : "D", e_addr,
                     idone ? e_iload : e_dload, cyc);

        n_owner = m_owner;
        if (m_owner == 0) begin
            if (dreq && !(bus.iREN && m_streak == MAXS)) n_owner = 2;
            else if (bus.iREN)                           n_owner = 1;
        end else begin
            req = (m_owner == 1) ? bus.iREN : dreq;
            expire = (rs != ACCESS) && (m_age == TMO - 1);
            if (!req) n_owner = 0;
            else if (rs == ACCESS) begin
                n_owner = 0;
                if (m_owner == 1 || !bus.iREN) m_streak = 0;
                else if (m_streak < MAXS)      m_streak = m_streak + 1;
            end else if (expire) n_owner = 0;
            if (expire) m_tmo = 1'b1;
            if (rs != ACCESS) m_age = m_age + 1;
        end
        m_icnt  += int'(idone);
        m_dcnt  += int'(ddone);
        m_stall += int'((bus.iREN && !idone) || (dreq && !ddone));

        @(posedge CLK);
        m_err_prev = granted && rs == ERROR;
        m_iload = e_iload;
        m_dload = e_dload;
        m_owner = n_owner;
        if (n_owner == 0) m_age = 0;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic step();
        #1;
        cycle();
    endtask

    task automatic set_req(input logic ir, input logic dr, input logic dw,
                           input word_t ia, input word_t da, input word_t ds);
        bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
        bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    endtask

    task automatic chk_reset_values();
        chk("rst_ramREN",   bus.ramREN,   1'b0);
        chk("rst_ramWEN",   bus.ramWEN,   1'b0);
        chk("rst_ramaddr",  bus.ramaddr,  32'h0);
        chk("rst_ramstore", bus.ramstore, 32'h0);
        chk("rst_iwait",    bus.iwait,    1'b1);
        chk("rst_dwait",    bus.dwait,    1'b1);
        chk("rst_iload",    bus.iload,    32'h0);
        chk("rst_dload",    bus.dload,    32'h0);
        chk("rst_ram_err",  ram_err,      1'b0);
        chk("rst_timeout",  timeout,      1'b0);
`ifdef RAM_ARB_STATS_EN
        chk("rst_i_count",  i_count,      32'h0);
        chk("rst_d_count",  d_count,      32'h0);
        chk("rst_stall",    stall_cycles, 32'h0);
`endif
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic iren, dren, dwen;
        word_t iaddr, daddr, dstore;
        ramstate_t rs;
        word_t rl;
        logic e_ren, e_wen;
        word_t e_addr, e_store;
        logic e_iwait, e_dwait;
        word_t e_iload, e_dload;
    } vec_t;

    vec_t tbl [16];

    // ---------------- main sequence ----------------
    initial begin
        int order [6];
        int k;
        int n_err;
        bit ok, iw_high;

        nRST = 1'b0; ram_mode = 1'b0; stim_state = FREE; stim_load = '0;
        set_req(0, 0, 0, '0, '0, '0);
        model_reset();
        #2;
        chk_reset_values();
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        //            ir dr dw iaddr     daddr     dstore        rs      rl            ren wen addr      store         iw dw iload         dload
        tbl[0]  = '{1, 0, 0, 32'h40, 32'h0,   32'h0,        FREE,   32'h0,        0, 0, 32'h0,   32'h0,        1, 1, 32'h0,        32'h0};
        tbl[1]  = '{1, 0, 0, 32'h40, 32'h0,   32'h0,        BUSY,   32'h0,        1, 0, 32'h40,  32'h0,        1, 1, 32'h0,        32'h0};
        tbl[2]  = '{1, 0, 0, 32'h40, 32'h0,   32'h0,        BUSY,   32'h0,        1, 0, 32'h40,  32'h0,        1, 1, 32'h0,        32'h0};
        tbl[3]  = '{1, 0, 0, 32'h40, 32'h0,   32'h0,        ACCESS, 32'h12345678, 1, 0, 32'h40,  32'h0,        0, 1, 32'h12345678, 32'h0};
        tbl[4]  = '{0, 0, 0, 32'h40, 32'h0,   32'h0,        FREE,   32'h0,        0, 0, 32'h0,   32'h0,        1, 1, 32'h12345678, 32'h0};
        tbl[5]  = '{0, 0, 1, 32'h0,  32'h100, 32'hDEADBEEF, FREE,   32'h0,        0, 0, 32'h0,   32'h0,        1, 1, 32'h12345678, 32'h0};
        tbl[6]  = '{0, 0, 1, 32'h0,  32'h100, 32'hDEADBEEF, BUSY,   32'h0,        0, 1, 32'h100, 32'hDEADBEEF, 1, 1, 32'h12345678, 32'h0};
        tbl[7]  = '{0, 0, 1, 32'h0,  32'h100, 32'hDEADBEEF, ACCESS, 32'h0,        0, 1, 32'h100, 32'hDEADBEEF, 1, 0, 32'h12345678, 32'h0};
        tbl[8]  = '{0, 1, 0, 32'h0,  32'h200, 32'h0,        FREE,   32'h0,        0, 0, 32'h0,   32'h0,        1, 1, 32'h12345678, 32'h0};
        tbl[9]  = '{0, 1, 0, 32'h0,  32'h200, 32'h0,        BUSY,   32'h0,        1, 0, 32'h200, 32'h0,        1, 1, 32'h12345678, 32'h0};
        tbl[10] = '{0, 1, 0, 32'h0,  32'h204, 32'h0,        ACCESS, 32'hCAFEF00D, 1, 0, 32'h204, 32'h0,        1, 0, 32'h12345678, 32'hCAFEF00D};
        tbl[11] = '{1, 1, 0, 32'h0,  32'h300, 32'h0,        FREE,   32'h0,        0, 0, 32'h0,   32'h0,        1, 1, 32'h12345678, 32'hCAFEF00D};
        tbl[12] = '{1, 1, 0, 32'h44, 32'h300, 32'h0,        BUSY,   32'h0,        1, 0, 32'h300, 32'h0,        1, 1, 32'h12345678, 32'hCAFEF00D};
        tbl[13] = '{1, 0, 0, 32'h44, 32'h300, 32'h0,        BUSY,   32'h0,        0, 0, 32'h300, 32'h0,        1, 1, 32'h12345678, 32'hCAFEF00D};
        tbl[14] = '{1, 0, 0, 32'h44, 32'h300, 32'h0,        FREE,   32'h0,        0, 0, 32'h0,   32'h0,        1, 1, 32'h12345678, 32'hCAFEF00D};
        tbl[15] = '{1, 0, 0, 32'h44, 32'h0,   32'h0,        ACCESS, 32'h55AA55AA, 1, 0, 32'h44,  32'h0,        0, 1, 32'h55AA55AA, 32'hCAFEF00D};

        for (int i = 0; i < 16; i++) begin
            set_req(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].iaddr, tbl[i].daddr, tbl[i].dstore);
            stim_state = tbl[i].rs;
            stim_load  = tbl[i].rl;
            #1;
            chk("tbl_ramREN",   bus.ramREN,   tbl[i].e_ren);
            chk("tbl_ramWEN",   bus.ramWEN,   tbl[i].e_wen);
            chk("tbl_ramaddr",  bus.ramaddr,  tbl[i].e_addr);
            chk("tbl_ramstore", bus.ramstore, tbl[i].e_store);
            chk("tbl_iwait",    bus.iwait,    tbl[i].e_iwait);
            chk("tbl_dwait",    bus.dwait,    tbl[i].e_dwait);
            chk("tbl_iload",    bus.iload,    tbl[i].e_iload);
            chk("tbl_dload",    bus.dload,    tbl[i].e_dload);
            cycle();
        end

        // Streak fairness: both ports requesting -> D D D D I D.
        order = '{2, 2, 2, 2, 1, 2};
        ram_mode = 1'b1;
        set_req(1, 1, 0, 32'h40, 32'h100, 32'h0);
        k = 0;
        for (int c = 0; c < 200 && k < 6; c++) begin
            step();
            if (obs_idone || obs_ddone) begin
                chk("streak_order", obs_idone ? 1 : 2, order[k]);
                k++;
            end
        end
        chk("streak_done", k, 6);

        // Data write then read back; the instruction port stays waiting.
        set_req(0, 0, 1, 32'h0, 32'h100, 32'hDEADBEEF);
        ok = 1'b0; iw_high = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            step();
            ok = obs_ddone;
            iw_high &= obs_iwait;
        end
        chk("write_done", ok, 1'b1);
        set_req(0, 1, 0, 32'h0, 32'h100, 32'h0);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            step();
            ok = obs_ddone;
            iw_high &= obs_iwait;
        end
        chk("read_done", ok, 1'b1);
        chk("read_back", obs_dload, 32'hDEADBEEF);
        chk("iwait_held", iw_high, 1'b1);

        // Illegal dREN&dWEN: one ram_err pulse, then timeout after TMO grant cycles.
        set_req(0, 1, 1, 32'h0, 32'h80, 32'h1);
        n_err = 0;
        for (int c = 0; c <= TMO; c++) begin
            step();
            n_err += int'(obs_err);
        end
        chk("timeout_late", obs_tmo, 1'b0);
        chk("err_pulses", n_err, 1);
        set_req(0, 0, 0, 32'h0, 32'h0, 32'h0);
        step();
        chk("timeout_set", obs_tmo, 1'b1);
        chk("timeout_idle", obs_ren, 1'b0);

        // Asynchronous reset in the middle of a data grant.
        set_req(0, 1, 0, 32'h0, 32'h100, 32'h0);
        step();
        step();
        #2;
        nRST = 1'b0;
        #1;
        chk_reset_values();
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        chk("fresh_arb_idle", obs_ren, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            step();
            ok = obs_ddone;
        end
        chk("post_reset_done", ok, 1'b1);

        // Randomized traffic against the model.
        verbose = 1'b0;
        ram_mode = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            int r;
            if ($urandom_range(0, 4) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(0, 4) == 0) bus.dREN = ~bus.dREN;
            if ($urandom_range(0, 5) == 0) bus.dWEN = ~bus.dWEN;
            if ($urandom_range(0, 7) == 0) bus.iaddr = $urandom;
            if ($urandom_range(0, 7) == 0) bus.daddr = $urandom;
            if ($urandom_range(0, 3) == 0) bus.dstore = $urandom;
            r = $urandom_range(0, 9);
            stim_state = (r == 0) ? FREE : (r == 1) ? ERROR : (r <= 4) ? ACCESS : BUSY;
            stim_load = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
